// File: rtl/fmps_read_link.sv
// Receives 2-beat FMPS packets from an Aurora AXI stream, stores the data word per index
// and tracks which indices arrived during the current fast-acquisition cycle.
module fmps_read_link #(
  parameter int          INDEX_WIDTH = 5,
  parameter logic [15:0] MAGIC       = 16'hB6CF
) (
  input  logic                        auroraClk,
  input  logic                        auroraReset,
  input  logic                        FAstrobe,
  input  logic                        allFMPSpresent,
  input  logic                        TVALID,
  input  logic                        TLAST,
  input  logic [31:0]                 TDATA,
  output logic                        statusStrobe,
  output logic [1:0]                  statusCode,
  output logic                        statusFMPSenabled,
  output logic [(1<<INDEX_WIDTH)-1:0] fmpsBitmap,
  output logic [INDEX_WIDTH:0]        fmpsCounter,
  input  logic [INDEX_WIDTH-1:0]      readoutAddress,
  output logic [31:0]                 readoutFMPS,
  output logic [1:0]                  parserState
);

  localparam int N = 1 << INDEX_WIDTH;

  // Stream has no TREADY: every TVALID beat is consumed in the cycle it appears.
  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   en_q, en_d;
  logic [1:0]             drain_code_q, drain_code_d;
  logic                   strobe_q, strobe_d;
  logic [1:0]             code_q, code_d;
  logic                   fen_q, fen_d;
  logic [N-1:0]           bitmap_q, bitmap_d;
  logic [INDEX_WIDTH:0]   count_q, count_d;
  logic [31:0]            readout_q;
  logic                   wr_en;
  logic [31:0]            mem [N];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    en_d         = en_q;
    drain_code_d = drain_code_q;
    strobe_d     = 1'b0;
    code_d       = code_q;
    fen_d        = fen_q;
    wr_en        = 1'b0;
    // A new acquisition cycle clears first, so a coincident completion lands in the new cycle.
    bitmap_d     = FAstrobe ? '0 : bitmap_q;
    count_d      = FAstrobe ? '0 : count_q;
    if (TVALID) begin
      case (state_q)
        S_HEADER: begin
          if (TLAST) begin
            strobe_d = 1'b1;
            code_d   = 2'd2;
          end else if (TDATA[31:16] != MAGIC) begin
            drain_code_d = 2'd1;
            state_d      = S_DRAIN;
          end else begin
            idx_d   = TDATA[10 +: INDEX_WIDTH];
            en_d    = TDATA[15];
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (TLAST) begin
            strobe_d = 1'b1;
            fen_d    = en_q;
            state_d  = S_HEADER;
            if (allFMPSpresent) begin
              code_d = 2'd3;
            end else begin
              code_d = 2'd0;
              wr_en  = 1'b1;
              if (!bitmap_d[idx_q]) count_d = count_d + (INDEX_WIDTH+1)'(1);
              bitmap_d[idx_q] = 1'b1;
            end
          end else begin
            drain_code_d = 2'd2;
            state_d      = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (TLAST) begin
            strobe_d = 1'b1;
            code_d   = drain_code_q;
            state_d  = S_HEADER;
          end
        end
        default: state_d = S_HEADER;
      endcase
    end
  end

  always_ff @(posedge auroraClk) begin
    if (auroraReset) begin
      state_q      <= S_HEADER;
      idx_q        <= '0;
      en_q         <= 1'b0;
      drain_code_q <= 2'd0;
      strobe_q     <= 1'b0;
      code_q       <= 2'd0;
      fen_q        <= 1'b0;
      bitmap_q     <= '0;
      count_q      <= '0;
      readout_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      en_q         <= en_d;
      drain_code_q <= drain_code_d;
      strobe_q     <= strobe_d;
      code_q       <= code_d;
      fen_q        <= fen_d;
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
      readout_q    <= mem[readoutAddress];
    end
  end

  // Table contents survive reset; a read in the write cycle returns the old word.
  always_ff @(posedge auroraClk) begin
    if (wr_en && !auroraReset) mem[idx_q] <= TDATA;
  end

  assign statusStrobe      = strobe_q;
  assign statusCode        = code_q;
  assign statusFMPSenabled = fen_q;
  assign fmpsBitmap        = bitmap_q;
  assign fmpsCounter       = count_q;
  assign readoutFMPS       = readout_q;
  assign parserState       = state_q;

endmodule

// File: tb/tb_fmps_read_link.sv
// Directed plus randomized packet sequences for fmps_read_link, checked against a
// packet-level reference model of the table, bitmap and status.
module tb_fmps_read_link;

  localparam logic [15:0] MAGIC = 16'hB6CF;

  logic        clk = 1'b0;
  logic        rst;
  logic        fa;
  logic        afp;
  logic        tvalid;
  logic        tlast;
  logic [31:0] tdata;
  logic        strobe;
  logic [1:0]  code;
  logic        fen;
  logic [31:0] bitmap;
  logic [5:0]  counter;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [1:0]  pstate;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_table [32];
  bit          m_valid [32];
  logic [31:0] m_bitmap;
  logic [1:0]  m_code;
  logic        m_en;
  logic [31:0] rd_at_done;

  fmps_read_link #(.INDEX_WIDTH(5), .MAGIC(16'hB6CF)) dut (
    .auroraClk(clk), .auroraReset(rst), .FAstrobe(fa), .allFMPSpresent(afp),
    .TVALID(tvalid), .TLAST(tlast), .TDATA(tdata),
    .statusStrobe(strobe), .statusCode(code), .statusFMPSenabled(fen),
    .fmpsBitmap(bitmap), .fmpsCounter(counter),
    .readoutAddress(raddr), .readoutFMPS(rdata), .parserState(pstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic f);
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tlast = last; fa = f;
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; fa = 1'b0; tdata = $urandom;
  endtask

  task automatic fa_pulse();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; fa = 1'b1;
    m_bitmap = '0;
  endtask

  // kind: 0 good, 1 bad magic, 2 single beat, 3 three beats
  task automatic send_pkt(input int kind, input logic [4:0] idx, input logic en,
                          input logic [31:0] data, input logic fa_first,
                          input logic fa_last, input logic all_present);
    logic [31:0] hdr;
    hdr = {(kind == 1) ? 16'hB6CE : MAGIC, en, idx, 10'($urandom)};
    afp = all_present;
    if (fa_first) m_bitmap = '0;
    case (kind)
      0, 1: begin
        beat(hdr, 1'b0, fa_first);
        if ($urandom_range(0, 3) == 0) idle();
        beat(data, 1'b1, fa_last);
      end
      2: beat(hdr, 1'b1, fa_first | fa_last);
      default: begin
        beat(hdr, 1'b0, fa_first);
        beat(data, 1'b0, 1'b0);
        beat($urandom, 1'b1, fa_last);
      end
    endcase
    if (fa_last) m_bitmap = '0;
    case (kind)
      0: begin
        m_en = en;
        if (all_present) m_code = 2'd3;
        else begin
          m_code = 2'd0;
          m_table[idx] = data;
          m_valid[idx] = 1'b1;
          m_bitmap[idx] = 1'b1;
        end
      end
      1: m_code = 2'd1;
      default: m_code = 2'd2;
    endcase
    idle();
    afp = 1'b0;
    rd_at_done = rdata;
    chk("strobe", 64'(strobe), 64'(1'b1));
    chk("code", 64'(code), 64'(m_code));
    chk("enabled", 64'(fen), 64'(m_en));
    chk("bitmap", 64'(bitmap), 64'(m_bitmap));
    chk("counter", 64'(counter), 64'($countones(m_bitmap)));
    idle();
    chk("strobe_low", 64'(strobe), 64'(1'b0));
    chk("state_idle", 64'(pstate), 64'(0));
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge clk);
    raddr = a;
    @(negedge clk);
    chk("readout", 64'(rdata), 64'(m_table[a]));
  endtask

  initial begin
    logic [31:0] old_word, new_word;
    rst = 1'b1; fa = 1'b0; afp = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; raddr = '0;
    m_bitmap = '0; m_code = 2'd0; m_en = 1'b0;
    for (int i = 0; i < 32; i++) begin m_table[i] = '0; m_valid[i] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("rst_strobe", 64'(strobe), 64'(0));
    chk("rst_code", 64'(code), 64'(0));
    chk("rst_enabled", 64'(fen), 64'(0));
    chk("rst_bitmap", 64'(bitmap), 64'(0));
    chk("rst_counter", 64'(counter), 64'(0));
    chk("rst_readout", 64'(rdata), 64'(0));
    chk("rst_state", 64'(pstate), 64'(0));
    rst = 1'b0;

    // Repeated index 1 counts once; readout returns the last word
    fa_pulse();
    for (int n = 0; n < 12; n++)
      send_pkt(0, 5'd1, 1'b1, {3'b0, 5'd1, 16'hCACA, 8'(n)}, 1'b0, 1'b0, 1'b0);
    chk("dup_counter", 64'(counter), 64'(1));
    chk("dup_bitmap", 64'(bitmap), 64'h2);
    rd(5'd1);
    chk("dup_word", 64'(rdata), 64'h01CACA0B);

    // Twelve distinct indices
    fa_pulse();
    for (int i = 0; i < 12; i++)
      send_pkt(0, 5'(i), 1'(i % 2), $urandom, 1'b0, 1'b0, 1'b0);
    chk("dist_counter", 64'(counter), 64'(12));
    chk("dist_bitmap", 64'(bitmap), 64'h00000FFF);
    for (int i = 0; i < 12; i++) rd(5'(i));

    // Bad magic, then a good packet; malformed lengths
    send_pkt(1, 5'd20, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    send_pkt(0, 5'd20, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    send_pkt(2, 5'd21, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    send_pkt(3, 5'd22, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);

    // Frozen table, then a new cycle empties the bitmap
    old_word = m_table[20];
    send_pkt(0, 5'd20, 1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    rd(5'd20);
    chk("frozen_word", 64'(rdata), 64'(old_word));
    fa_pulse();
    idle();
    chk("fa_bitmap", 64'(bitmap), 64'(0));
    chk("fa_counter", 64'(counter), 64'(0));

    // FAstrobe coincident with completion of index 5 after seven entries
    for (int i = 0; i < 7; i++) send_pkt(0, 5'(i + 8), 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    chk("pre_counter", 64'(counter), 64'(7));
    send_pkt(0, 5'd5, 1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    chk("coinc_counter", 64'(counter), 64'(1));
    chk("coinc_bitmap", 64'(bitmap), 64'h20);

    // FAstrobe on the header beat
    send_pkt(0, 5'd6, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);

    // Read in the write cycle returns the old word
    old_word = m_table[9];
    new_word = $urandom;
    @(negedge clk);
    raddr = 5'd9;
    send_pkt(0, 5'd9, 1'b1, new_word, 1'b0, 1'b0, 1'b0);
    chk("rw_old", 64'(rd_at_done), 64'(old_word));
    chk("rw_new", 64'(rdata), 64'(new_word));

    // Reset mid-packet abandons it and overrides FAstrobe
    beat({MAGIC, 1'b1, 5'd3, 10'd0}, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; tvalid = 1'b1; tlast = 1'b1; tdata = $urandom; fa = 1'b1;
    @(negedge clk);
    rst = 1'b0; tvalid = 1'b0; tlast = 1'b0; fa = 1'b0;
    m_bitmap = '0; m_code = 2'd0; m_en = 1'b0;
    chk("mrst_strobe", 64'(strobe), 64'(0));
    chk("mrst_state", 64'(pstate), 64'(0));
    chk("mrst_bitmap", 64'(bitmap), 64'(0));
    chk("mrst_code", 64'(code), 64'(0));
    send_pkt(0, 5'd3, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    rd(5'd9);

    // Randomized traffic over the full index range
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 11);
      send_pkt((r < 8) ? 0 : (r == 8) ? 1 : (r == 9) ? 2 : (r == 10) ? 3 : 0,
               5'($urandom), 1'($urandom), $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, r == 11);
    end
    for (int i = 0; i < 32; i++) if (m_valid[i]) rd(5'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmps_read_link.md
FMPS_READ_LINK -- requirements
Module: fmps_read_link

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 5, the FMPS index width; the table holds 2^INDEX_WIDTH entries.
REQ-002 SHALL have parameter MAGIC, default 16'hB6CF, the expected header magic.
REQ-003 auroraClk  in  1  sole clock; all logic on its rising edge.
REQ-004 auroraReset  in  1  synchronous, active-high reset.
REQ-005 FAstrobe  in  1  one-cycle fast-acquisition cycle marker.
REQ-006 allFMPSpresent  in  1  consumer is reading the table; table writes are frozen.
REQ-007 TVALID, TLAST  in  1 each  AXI-stream beat qualifiers; no TREADY, every TVALID beat is consumed.
REQ-008 TDATA  in  32  stream data.
REQ-009 statusStrobe  out  1  one-cycle pulse per completed packet.
REQ-010 statusCode  out  2  result of last packet: 0 OK, 1 bad magic, 2 bad length, 3 dropped (frozen).
REQ-011 statusFMPSenabled  out  1  header bit 15 of last good-magic packet.
REQ-012 fmpsBitmap  out  2^INDEX_WIDTH  bit i set = entry i received this cycle.
REQ-013 fmpsCounter  out  INDEX_WIDTH+1  number of distinct indices received this cycle.
REQ-014 readoutAddress  in  INDEX_WIDTH  table read address.
REQ-015 readoutFMPS  out  32  stored data word at readoutAddress.

Function
REQ-016 Packet SHALL be exactly 2 beats: header then data word (TLAST on data word only).
REQ-017 Header fields SHALL be: [31:16] magic, [15] FMPS-enabled, [14:10] index (INDEX_WIDTH bits from bit 10), [9:0] ignored.
REQ-018 Data word SHALL be stored verbatim (fields [31] FMPS2CC invalid, [30] CC2CC invalid, [29] reserved, [28:24] index, [23:8] data magic, [7:0] cycle counter are not interpreted).
REQ-019 Parser SHALL have states HEADER, DATA, DRAIN; reset state HEADER; non-TVALID cycles hold state.
REQ-020 HEADER + TVALID: TLAST=1 -> code 2, strobe, stay HEADER; magic mismatch -> latch code 1, go DRAIN; else latch index and enabled bit, go DATA.
REQ-021 DATA + TVALID: TLAST=1 -> complete packet, go HEADER; TLAST=0 -> latch code 2, go DRAIN.
REQ-022 DRAIN + TVALID + TLAST -> strobe with latched code, go HEADER; other beats discarded.
REQ-023 On completion with allFMPSpresent=0: write data word to table[index], set fmpsBitmap[index], increment fmpsCounter only if bit was clear, code 0.
REQ-024 On completion with allFMPSpresent=1: no table/bitmap/counter change, code 3.
REQ-025 Duplicate index in one cycle SHALL overwrite the entry, code 0, counter unchanged.
REQ-026 statusStrobe, statusCode, statusFMPSenabled, bitmap and counter SHALL update on the edge after the TLAST beat (1-cycle latency); statusCode/statusFMPSenabled hold between strobes.
REQ-027 FAstrobe SHALL clear fmpsBitmap and fmpsCounter on the next edge; parser state and table contents unaffected.
REQ-028 FAstrobe coincident with a completing packet: clear then record, leaving bitmap = only that index, counter = 1.
REQ-029 FAstrobe mid-packet: packet continues and is recorded in the new cycle.
REQ-030 readoutFMPS SHALL be registered, 1-cycle latency from readoutAddress; same-cycle write/read to same address returns old data.
REQ-031 fmpsCounter SHALL never exceed 2^INDEX_WIDTH.

Reset
REQ-032 auroraReset SHALL force state HEADER, fmpsBitmap 0, fmpsCounter 0, statusStrobe 0, statusCode 0, statusFMPSenabled 0, readoutFMPS 0; table RAM not cleared.
REQ-033 Reset mid-packet SHALL abandon it without strobe; reset overrides FAstrobe.

Verification
REQ-034 FAstrobe, then 12 packets index 1, magic B6CF, data {3'b0,5'd1,16'hCACA,8'hN} -> counter 12 only if distinct; with index 1 repeated, counter 1, bitmap 32'h2, readout@1 = 0x01CACA0N after 1 cycle.
REQ-035 Indices 0..11 after FAstrobe -> fmpsCounter 12, bitmap 32'h00000FFF, each readout returns its word, codes all 0.
REQ-036 Header magic 0xB6CE -> strobe with code 1, bitmap unchanged; following good packet accepted.
REQ-037 Single-beat packet (TLAST on header) -> code 2; 3-beat packet -> code 2 after final TLAST, nothing stored.
REQ-038 allFMPSpresent=1 during packet completion -> code 3, bitmap/counter/table unchanged; next FAstrobe -> bitmap 0, counter 0.
REQ-039 FAstrobe on same cycle as TLAST of index 5 with counter 7 -> counter 1, bitmap 32'h20.
